// File: rtl/fb_scan_out.sv
// ----------------------------------------------------------------------------
// fb_scan_out
//
// Read-side scanner for a 320x240 RGB565 frame buffer. It generates 640x480@60
// VGA timing from the system clock. It addresses the buffer with 2x2 pixel
// doubling. The returned pixel is registered as 12-bit RGB, aligned with
// hsync/vsync.
//
// Ports
//   clk           in   1   system clock
//   reset         in   1   synchronous, active-high reset
//   read_addr     out  17  frame buffer read address (registered every clk)
//   vga_pixel     in   16  RGB565 read data, valid 1 clk after read_addr
//   rgb           out  12  {R[3:0],G[3:0],B[3:0]} to the VGA DAC
//   hsync         out  1   horizontal sync, active low
//   vsync         out  1   vertical sync, active low
//   vblank_start  out  1   1-clk pulse on the tick that enters vertical blanking
//
// CLK_DIV must be >= 3. The pipeline runs as follows:
//   - The counters settle at tick cycle T.
//   - read_addr is valid at T+1.
//   - vga_pixel is valid at T+2.
//   - vga_pixel is captured on the next tick, at T+CLK_DIV.
// ----------------------------------------------------------------------------
module fb_scan_out #(
  parameter int CLK_DIV = 4,
  parameter int H_VIS   = 640,
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int V_VIS   = 480,
  parameter int V_FP    = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33,
  parameter int FB_W    = 320
) (
  input  logic        clk,
  input  logic        reset,
  output logic [16:0] read_addr,
  input  logic [15:0] vga_pixel,
  output logic [11:0] rgb,
  output logic        hsync,
  output logic        vsync,
  output logic        vblank_start
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int HW    = $clog2(H_TOT);
  localparam int VW    = $clog2(V_TOT);

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_PRE  = DW'(CLK_DIV - 2);
  localparam logic [HW-1:0] H_LAST   = HW'(H_TOT - 1);
  localparam logic [HW-1:0] H_VIS_C  = HW'(H_VIS);
  localparam logic [HW-1:0] HS_BEG   = HW'(H_VIS + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_VIS + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOT - 1);
  localparam logic [VW-1:0] V_VIS_C  = VW'(V_VIS);
  localparam logic [VW-1:0] V_VB     = VW'(V_VIS - 1);
  localparam logic [VW-1:0] VS_BEG   = VW'(V_VIS + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_VIS + V_FP + V_SYNC);
  localparam logic [16:0]   FB_W_C   = 17'(FB_W);

  logic [DW-1:0] div_q, div_d;
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic [16:0]   addr_q, addr_d;
  logic [11:0]   rgb_q, rgb_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          vblank_q, vblank_d;

  logic          tick;
  logic          visible;

  assign tick    = (div_q == DIV_LAST);
  assign visible = (h_q < H_VIS_C) && (v_q < V_VIS_C);

  // Only the 4 MSBs of each RGB565 channel reach the DAC.
  logic unused_pixel_bits;
  assign unused_pixel_bits = ^{vga_pixel[11], vga_pixel[6:5], vga_pixel[0]};

  always_comb begin
    // NOTE: every always_comb output gets a default first so that no path
    // leaves it unassigned (which would infer a latch).
    div_d    = tick ? '0 : div_q + 1'b1;
    h_d      = h_q;
    v_d      = v_q;
    rgb_d    = rgb_q;
    hsync_d  = hsync_q;
    vsync_d  = vsync_q;

    // The address is recomputed every clk from the current counters.
    // This gives the RAM a full clk of read latency before the next tick.
    addr_d = '0;
    if (visible) begin
      addr_d = 17'(v_q >> 1) * FB_W_C + 17'(h_q >> 1);
    end

    // The output registers sample the position being left. Output pixel k
    // therefore shows counter position k, with zero skew between rgb and sync.
    if (tick) begin
      rgb_d   = visible ? {vga_pixel[15:12], vga_pixel[10:7], vga_pixel[4:1]} : 12'h000;
      hsync_d = ~((h_q >= HS_BEG) && (h_q < HS_END));
      vsync_d = ~((v_q >= VS_BEG) && (v_q < VS_END));
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
    end

    // The pulse is registered one clk early, from div == CLK_DIV-2. The
    // registered output is then high exactly during the tick cycle at
    // (H_LAST, V_VIS-1), and it stays glitch-free.
    vblank_d = (div_q == DIV_PRE) && (h_q == H_LAST) && (v_q == V_VB);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    if (reset) begin
      div_q    <= '0;
      h_q      <= '0;
      v_q      <= '0;
      addr_q   <= '0;
      rgb_q    <= '0;
      hsync_q  <= 1'b1;
      vsync_q  <= 1'b1;
      vblank_q <= 1'b0;
    end else begin
      div_q    <= div_d;
      h_q      <= h_d;
      v_q      <= v_d;
      addr_q   <= addr_d;
      rgb_q    <= rgb_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      vblank_q <= vblank_d;
    end
  end

  assign read_addr    = addr_q;
  assign rgb          = rgb_q;
  assign hsync        = hsync_q;
  assign vsync        = vsync_q;
  assign vblank_start = vblank_q;

endmodule
